// File: rtl/rf_pkg.sv
// Shared constants and the grant encoding for the register-file FIFO controller.
// The arbitration helper is kept here so the grant rule lives in one place.
package rf_pkg;

    localparam int DW        = 12;
    localparam int AW        = 8;
    localparam int RAW       = 6;
    localparam int CAW       = 2;
    localparam int PF_DEPTH  = 3;
    localparam int RD_LAT    = 2;
    localparam int RAM_WORDS = 1 << AW;
    localparam int PFCW      = $clog2(PF_DEPTH + 1);
    localparam int IFW       = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    // Round-robin bit only matters when both sides want the port (rr=0 favours write).
    function automatic gnt_e arbitrate(input logic wr_req, input logic rd_req, input logic rr);
        if (wr_req && rd_req) begin
            return rr ? GNT_RD : GNT_WR;
        end
        if (wr_req) begin
            return GNT_WR;
        end
        if (rd_req) begin
            return GNT_RD;
        end
        return GNT_IDLE;
    endfunction

endpackage

// File: rtl/rf_fifo_ctrl_if.sv
// Push and pop valid/ready streams of the FIFO controller.
// slave is the controller side, master is the producer/consumer side.
interface rf_fifo_ctrl_if;
    import rf_pkg::*;

    logic          IN_VALID;
    logic [DW-1:0] IN_DATA;
    logic          IN_READY;
    logic          OUT_VALID;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_READY;

    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA
    );

    modport master (
        output IN_VALID, IN_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA
    );

endinterface

// File: rtl/rf_prefetch_buf.sv
// Small register FIFO that holds words already read from the macro.
// The head entry is presented combinationally; push and pop may coincide.
module rf_prefetch_buf #(
    parameter int DEPTH = 3,
    parameter int W     = 12,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entries are cleared on reset so the head reads zero out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (srst) begin
                    mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q == PW'(gi))) begin
                    mem_q[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign head_data = mem_q[rd_ptr_q];
    assign count     = cnt_q;

endmodule

// File: rtl/rf_fifo_ctrl.sv
// FIFO controller sharing the single port of a 256x12 register-file macro between a push
// stream and a pop stream; a prefetch buffer covers the two-cycle macro read latency.
module rf_fifo_ctrl
    import rf_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    rf_fifo_ctrl_if.slave   fifo,
    output logic            NCE,
    output logic            NWRT,
    output logic [RAW-1:0]  RA,
    output logic [CAW-1:0]  CA,
    output logic [DW-1:0]   DIN,
    input  logic [DW-1:0]   DO,
    output logic [AW:0]     COUNT,
    output logic            FULL,
    output logic            EMPTY
);

    localparam int          OCW          = PFCW + 2;
    localparam logic [AW:0] RAM_FULL_CNT = (AW + 1)'(RAM_WORDS);

    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [AW:0]       ram_cnt_q, ram_cnt_d;
    logic [IFW-1:0]    inflight_q, inflight_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic              rr_q, rr_d;
    logic              nce_q, nce_d;
    logic              nwrt_q, nwrt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     din_q, din_d;

    logic [PFCW-1:0]   pf_cnt;
    logic [DW-1:0]     pf_head;
    logic [OCW-1:0]    occ;
    logic              out_valid, pop, capture;
    logic              ram_full, wr_req, rd_req, wr_gnt, rd_gnt;
    gnt_e              gnt;

    assign out_valid = (pf_cnt != '0);
    assign pop       = out_valid && fifo.OUT_READY;
    assign capture   = tag_q[RD_LAT-1];
    assign ram_full  = (ram_cnt_q == RAM_FULL_CNT);
    // Slots already promised to the buffer (held + in flight), net of this cycle's pop.
    assign occ       = OCW'(pf_cnt) + OCW'(inflight_q) - OCW'(pop);
    assign wr_req    = fifo.IN_VALID && !ram_full;
    assign rd_req    = (ram_cnt_q != '0) && (occ < OCW'(PF_DEPTH));
    assign gnt       = arbitrate(wr_req, rd_req, rr_q);
    assign wr_gnt    = (gnt == GNT_WR);
    assign rd_gnt    = (gnt == GNT_RD);

    always_comb begin
        wp_d       = wr_gnt ? wp_q + 1'b1 : wp_q;
        rp_d       = rd_gnt ? rp_q + 1'b1 : rp_q;
        ram_cnt_d  = ram_cnt_q + (AW + 1)'(wr_gnt) - (AW + 1)'(rd_gnt);
        inflight_d = inflight_q + IFW'(rd_gnt) - IFW'(capture);
        tag_d      = {tag_q[RD_LAT-2:0], rd_gnt};
        rr_d       = (wr_req && rd_req) ? ~rr_q : rr_q;
        nce_d      = (gnt == GNT_IDLE);
        nwrt_d     = !wr_gnt;
        addr_d     = addr_q;
        din_d      = din_q;
        if (wr_gnt) begin
            addr_d = wp_q;
            din_d  = fifo.IN_DATA;
        end else if (rd_gnt) begin
            addr_d = rp_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wp_q       <= '0;
            rp_q       <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= '0;
            tag_q      <= '0;
            rr_q       <= 1'b0;
            nce_q      <= 1'b1;
            nwrt_q     <= 1'b1;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            rr_q       <= rr_d;
            nce_q      <= nce_d;
            nwrt_q     <= nwrt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    rf_prefetch_buf #(
        .DEPTH (PF_DEPTH),
        .W     (DW)
    ) u_pf (
        .clk       (CLK),
        .srst      (RST),
        .push      (capture),
        .push_data (DO),
        .pop       (pop),
        .head_data (pf_head),
        .count     (pf_cnt)
    );

    assign fifo.IN_READY  = !RST && !ram_full && !(rd_req && rr_q);
    assign fifo.OUT_VALID = out_valid;
    assign fifo.OUT_DATA  = pf_head;

    assign NCE   = nce_q;
    assign NWRT  = nwrt_q;
    assign RA    = addr_q[AW-1:CAW];
    assign CA    = addr_q[CAW-1:0];
    assign DIN   = din_q;
    assign COUNT = ram_cnt_q + (AW + 1)'(inflight_q) + (AW + 1)'(pf_cnt);
    assign FULL  = ram_full;
    assign EMPTY = (COUNT == '0);

endmodule

// File: tb/tb_rf_fifo_ctrl.sv
// Bench for rf_fifo_ctrl with a behavioural register-file macro and a pop-side scoreboard.
// Directed tests drive the streams; a negedge monitor checks popped data and macro address order.
module tb_rf_fifo_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic        NCE, NWRT;
    logic [5:0]  RA;
    logic [1:0]  CA;
    logic [11:0] DIN, DO;
    logic [8:0]  COUNT;
    logic        FULL, EMPTY;

    rf_fifo_ctrl_if bus();

    rf_fifo_ctrl dut (
        .CLK   (clk),
        .RST   (RST),
        .fifo  (bus),
        .NCE   (NCE),
        .NWRT  (NWRT),
        .RA    (RA),
        .CA    (CA),
        .DIN   (DIN),
        .DO    (DO),
        .COUNT (COUNT),
        .FULL  (FULL),
        .EMPTY (EMPTY)
    );

    always #5 clk = ~clk;

    // Macro model: inputs sampled at the edge after the controller registers them.
    logic [11:0] mem [256];
    logic [11:0] do_r;
    assign DO = do_r;
    always @(posedge clk) begin
        if (NCE === 1'b0) begin
            if (NWRT === 1'b0) mem[{RA, CA}] <= DIN;
            else               do_r <= mem[{RA, CA}];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard and macro-order monitor, sampled mid-cycle.
    logic [11:0] exp_q[$];
    logic [11:0] exp_word;
    logic [7:0]  exp_wr_addr, exp_rd_addr, last_wr, last_rd;
    bit          wr_seen, rd_seen;
    int          wr_wraps = 0, rd_wraps = 0;

    always @(negedge clk) begin
        if (RST) begin
            exp_q.delete();
            exp_wr_addr = 8'h00;
            exp_rd_addr = 8'h00;
            wr_seen     = 1'b0;
            rd_seen     = 1'b0;
        end else begin
            if (bus.OUT_VALID === 1'b1 && bus.OUT_READY) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", {20'h0, bus.OUT_DATA}, 32'hFFFF_FFFF);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("pop_data", {20'h0, bus.OUT_DATA}, {20'h0, exp_word});
                end
            end
            if (bus.IN_VALID && bus.IN_READY === 1'b1) exp_q.push_back(bus.IN_DATA);
            if (NCE === 1'b0) begin
                if (NWRT) begin
                    check("rd_addr_order", {24'h0, RA, CA}, {24'h0, exp_rd_addr});
                    if (rd_seen && last_rd == 8'hFF && {RA, CA} == 8'h00) rd_wraps++;
                    last_rd = {RA, CA};
                    rd_seen = 1'b1;
                    exp_rd_addr++;
                end else begin
                    check("wr_addr_order", {24'h0, RA, CA}, {24'h0, exp_wr_addr});
                    if (wr_seen && last_wr == 8'hFF && {RA, CA} == 8'h00) wr_wraps++;
                    last_wr = {RA, CA};
                    wr_seen = 1'b1;
                    exp_wr_addr++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and holds it until accepted or max_wait cycles elapse; IN_VALID stays high.
    task automatic push(input logic [11:0] d, input int max_wait, output bit acc);
        acc = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = d;
        for (int w = 0; w < max_wait && !acc; w++) begin
            @(negedge clk);
            if (bus.IN_READY === 1'b1) acc = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_empty(input string name, input int max_cycles);
        bit done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            tick();
            if (EMPTY === 1'b1) done = 1'b1;
        end
        check(name, {31'h0, done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc, viol, idle_cnt, same_cnt, cmin, cmax;
        logic prev_nwrt;

        // Reset with random inputs
        RST = 1'b1;
        bus.IN_VALID  = 1'($urandom);
        bus.IN_DATA   = 12'($urandom);
        bus.OUT_READY = 1'($urandom);
        tick();
        check("rst_nce_c1", {31'h0, NCE}, 32'h1);
        bus.IN_VALID  = 1'($urandom);
        bus.IN_DATA   = 12'($urandom);
        bus.OUT_READY = 1'($urandom);
        tick();
        check("rst_nce_c2", {31'h0, NCE}, 32'h1);
        check("rst_nwrt", {31'h0, NWRT}, 32'h1);
        check("rst_ra", {26'h0, RA}, 32'h0);
        check("rst_ca", {30'h0, CA}, 32'h0);
        check("rst_din", {20'h0, DIN}, 32'h0);
        check("rst_out_valid", {31'h0, bus.OUT_VALID}, 32'h0);
        check("rst_out_data", {20'h0, bus.OUT_DATA}, 32'h0);
        check("rst_in_ready", {31'h0, bus.IN_READY}, 32'h0);
        check("rst_count", {23'h0, COUNT}, 32'h0);
        check("rst_full", {31'h0, FULL}, 32'h0);
        check("rst_empty", {31'h0, EMPTY}, 32'h1);
        RST = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = 12'h000;
        bus.OUT_READY = 1'b0;
        #1;
        check("idle_in_ready", {31'h0, bus.IN_READY}, 32'h1);

        // Single push of ABC: write after edge k, read after k+1, OUT_VALID after k+3
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 12'hABC;
        tick();
        bus.IN_VALID = 1'b0;
        check("push_nce", {31'h0, NCE}, 32'h0);
        check("push_nwrt", {31'h0, NWRT}, 32'h0);
        check("push_addr", {24'h0, RA, CA}, 32'h0);
        check("push_din", {20'h0, DIN}, 32'hABC);
        check("push_count", {23'h0, COUNT}, 32'h1);
        tick();
        check("rd_grant_nce", {31'h0, NCE}, 32'h0);
        check("rd_grant_nwrt", {31'h0, NWRT}, 32'h1);
        check("ov_k1", {31'h0, bus.OUT_VALID}, 32'h0);
        tick();
        check("ov_k2", {31'h0, bus.OUT_VALID}, 32'h0);
        tick();
        check("ov_k3", {31'h0, bus.OUT_VALID}, 32'h1);
        check("od_k3", {20'h0, bus.OUT_DATA}, 32'hABC);
        check("count_k3", {23'h0, COUNT}, 32'h1);
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
        check("single_empty", {31'h0, EMPTY}, 32'h1);

        // Fill with no pops: RAM fills to 256 while 3 words sit in the prefetch buffer
        n_acc = 0;
        for (int i = 0; i < 300; i++) begin
            push(12'(i), 10, acc);
            if (!acc) break;
            n_acc++;
        end
        check("fill_accepted", n_acc, 259);
        check("fill_full", {31'h0, FULL}, 32'h1);
        check("fill_in_ready", {31'h0, bus.IN_READY}, 32'h0);
        check("fill_count", {23'h0, COUNT}, 32'd259);
        check("fill_empty", {31'h0, EMPTY}, 32'h0);
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        wait_empty("fill_drain", 1000);
        bus.OUT_READY = 1'b0;
        check("fill_sb_left", exp_q.size(), 0);

        // Contention: continuous push and pop with data present
        for (int i = 0; i < 10; i++) begin
            push(12'h100 + 12'(i), 10, acc);
            check("cont_prefill", {31'h0, acc}, 32'h1);
        end
        bus.IN_VALID = 1'b0;
        tick();
        n_acc = 0;
        idle_cnt = 0;
        same_cnt = 0;
        cmin = 999;
        cmax = 0;
        fork
            begin
                bus.OUT_READY = 1'b1;
                for (int i = 0; i < 60; i++) begin
                    push(12'h110 + 12'(i), 10, acc);
                    if (acc) n_acc++;
                end
                bus.IN_VALID = 1'b0;
            end
            begin
                repeat (12) @(negedge clk);
                prev_nwrt = NWRT;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (NCE !== 1'b0) idle_cnt++;
                    else if (NWRT === prev_nwrt) same_cnt++;
                    prev_nwrt = NWRT;
                    if (int'(COUNT) < cmin) cmin = int'(COUNT);
                    if (int'(COUNT) > cmax) cmax = int'(COUNT);
                end
            end
        join
        check("cont_accepted", n_acc, 60);
        check("cont_idle", idle_cnt, 0);
        check("cont_alternate", same_cnt, 0);
        check("cont_count_span_le1", {31'h0, (cmax - cmin) <= 1}, 32'h1);
        wait_empty("cont_drain", 300);
        bus.OUT_READY = 1'b0;
        check("cont_sb_left", exp_q.size(), 0);

        // Wrap-around: 300 words streamed through with the consumer always ready
        n_acc = 0;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push(12'h200 + 12'(i), 10, acc);
            if (acc) n_acc++;
        end
        bus.IN_VALID = 1'b0;
        check("wrap_accepted", n_acc, 300);
        wait_empty("wrap_drain", 300);
        bus.OUT_READY = 1'b0;
        check("wrap_sb_left", exp_q.size(), 0);
        check("wr_addr_wraps", wr_wraps, 2);
        check("rd_addr_wraps", rd_wraps, 2);

        // Reset one cycle after a read grant: the in-flight word must vanish
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 12'h5A5;
        tick();
        bus.IN_VALID = 1'b0;
        tick();
        check("midrd_grant", {30'h0, NCE, NWRT}, 32'h1);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        viol = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.OUT_VALID !== 1'b0) viol++;
        end
        check("midrd_no_out_valid", viol, 0);
        check("midrd_count", {23'h0, COUNT}, 32'h0);
        check("midrd_empty", {31'h0, EMPTY}, 32'h1);
        push(12'h3C3, 10, acc);
        bus.IN_VALID = 1'b0;
        check("midrd_push_acc", {31'h0, acc}, 32'h1);
        acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) begin
            if (bus.OUT_VALID === 1'b1) acc = 1'b1;
            else tick();
        end
        check("midrd_out_valid", {31'h0, acc}, 32'h1);
        check("midrd_out_data", {20'h0, bus.OUT_DATA}, 32'h3C3);
        bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
        tick();
        check("midrd_sb_left", exp_q.size(), 0);
        check("final_empty", {31'h0, EMPTY}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
